hazard_ctrl: RTL and testbench

Pipeline stall/flush/forwarding controller for the five-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and drives them: it holds or bubbles them on load-use hazards and multi-cycle multiply/divide operations, and flushes them on taken branches. It also selects the EX-stage operand forwarding sources and counts stall cycles.

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Stall / flush / forwarding controller for the five-stage MIPS pipeline.
// Holds or bubbles the IF/ID and ID/EX registers on load-use hazards and on
// multi-cycle multiply/divide operations, flushes them on taken branches,
// selects the EX-stage operand forwarding sources and counts stall cycles.
//
// Handshake with the MDU: mdu_start is a level that stays high while the
// multiply/divide sits in EX; mdu_done is sampled every cycle and releases the
// pipeline in the same cycle it is seen. No valid/ready pairs are involved.
//
// Ports
//   clock, reset                 clock (rising edge), async active-high reset
//   id_rs, id_rt                 source registers of the instruction in ID
//   ex_rs, ex_rt                 source registers held in ID/EX
//   ex_memctrl                   ID/EX memctrl: [1] mem read, [0] mem write
//   exmem_rd, exmem_regwrite     EX/MEM destination and writeback enable
//   memwb_rd, memwb_regwrite     MEM/WB destination and writeback enable
//   branch_taken                 taken branch/jump resolved in EX
//   mdu_start, mdu_done          MDU operation in EX / MDU result ready
//   pc_en, ifid_en, idex_en      pipeline load enables
//   ifid_flush, idex_flush       pipeline clear-to-bubble
//   fwd_a, fwd_b                 EX operand select (00 RF, 10 EX/MEM, 01 MEM/WB)
//   mdu_timeout                  sticky flag: MDU never answered in time
//   stall_cnt                    saturating count of cycles with pc_en = 0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [1:0]       ex_memctrl,
  input  logic [4:0]       exmem_rd,
  input  logic [4:0]       memwb_rd,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  // The wait counter only has to reach MDU_TIMEOUT-1: the timeout fires on
  // the cycle the counter already holds that value.
  localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               pc_en_c, ifid_en_c, idex_en_c, ifid_flush_c, idex_flush_c;
  logic               load_use;
  logic [1:0]         fwd_a_c, fwd_b_c;

  // The store bit of memctrl plays no part in hazard detection.
  logic               unused_memwrite;
  assign unused_memwrite = ex_memctrl[0];

  // A load in EX whose destination (rt) is read by the instruction in ID.
  assign load_use = ex_memctrl[1] && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Forwarding source for one EX operand; the younger EX/MEM result wins.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       em_we,
    input logic [4:0] em_rd,
    input logic       mw_we,
    input logic [4:0] mw_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
      sel = 2'b10;
    end else if (mw_we && (mw_rd != 5'd0) && (mw_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    fwd_a_c = fwd_sel(ex_rs, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
    fwd_b_c = fwd_sel(ex_rt, exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd);
  end

  // Next-state and stall/flush decode.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (branch_taken) begin
          // Wrong-path instructions in IF/ID and ID/EX are discarded; any
          // MDU op or load-use pair among them no longer matters.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (mdu_start) begin
          if (!mdu_done) begin
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            idex_en_c  = 1'b0;
            state_d    = ST_MDU_WAIT;
            wait_cnt_d = '0;
          end
        end else if (load_use) begin
          // Hold PC and IF/ID, inject one bubble into ID/EX.
          pc_en_c      = 1'b0;
          ifid_en_c    = 1'b0;
          idex_flush_c = 1'b1;
        end
      end

      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Give up on the MDU: release as if it had answered and flag it.
          state_d   = ST_RUN;
          timeout_d = 1'b1;
        end else begin
          pc_en_c    = 1'b0;
          ifid_en_c  = 1'b0;
          idex_en_c  = 1'b0;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is held the pipeline is frozen and nothing is forwarded.
  assign pc_en       = pc_en_c      & ~reset;
  assign ifid_en     = ifid_en_c    & ~reset;
  assign idex_en     = idex_en_c    & ~reset;
  assign ifid_flush  = ifid_flush_c & ~reset;
  assign idex_flush  = idex_flush_c & ~reset;
  assign fwd_a       = reset ? 2'b00 : fwd_a_c;
  assign fwd_b       = reset ? 2'b00 : fwd_b_c;
  assign mdu_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt;
  logic [1:0]  ex_memctrl;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic        branch_taken, mdu_start, mdu_done;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic        mdu_timeout;
  logic [15:0] stall_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic        s_mdu_timeout;
  logic [2:0]  s_stall_cnt;

  int checks;
  int failures;
  int exp_stall;

  // Expected output bundle: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b}
  logic [8:0] exp_q[$];

  localparam logic [8:0] E_IDLE = 9'b11010_0000;
  localparam logic [8:0] E_LU   = 9'b00011_0000;
  localparam logic [8:0] E_BR   = 9'b11111_0000;
  localparam logic [8:0] E_MDU  = 9'b00000_0000;

  hazard_ctrl #(.MDU_TIMEOUT(64), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memctrl(ex_memctrl),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mdu_timeout(mdu_timeout), .stall_cnt(stall_cnt)
  );

  // Narrow counter / short timeout copy to reach saturation quickly.
  hazard_ctrl #(.MDU_TIMEOUT(4), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_memctrl(ex_memctrl),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_flush(s_idex_flush),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .mdu_timeout(s_mdu_timeout), .stall_cnt(s_stall_cnt)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic [1:0] memctrl;
    logic [4:0] exmem_rd, memwb_rd;
    logic       exmem_rw, memwb_rw, br, start, done;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(
    input logic [4:0] a_id_rs, input logic [4:0] a_id_rt,
    input logic [4:0] a_ex_rs, input logic [4:0] a_ex_rt,
    input logic [1:0] a_mc,
    input logic [4:0] a_em_rd, input logic [4:0] a_mw_rd,
    input logic a_em_rw, input logic a_mw_rw,
    input logic a_br, input logic a_st, input logic a_dn,
    input logic [8:0] a_exp
  );
    vec_t v;
    v.id_rs = a_id_rs; v.id_rt = a_id_rt; v.ex_rs = a_ex_rs; v.ex_rt = a_ex_rt;
    v.memctrl = a_mc; v.exmem_rd = a_em_rd; v.memwb_rd = a_mw_rd;
    v.exmem_rw = a_em_rw; v.memwb_rw = a_mw_rw;
    v.br = a_br; v.start = a_st; v.done = a_dn; v.exp = a_exp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_memctrl = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    branch_taken = 0; mdu_start = 0; mdu_done = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_memctrl = v.memctrl; exmem_rd = v.exmem_rd; memwb_rd = v.memwb_rd;
    exmem_regwrite = v.exmem_rw; memwb_regwrite = v.memwb_rw;
    branch_taken = v.br; mdu_start = v.start; mdu_done = v.done;
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_head(input string name);
    logic [8:0] got;
    logic [8:0] exp;
    got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, fwd_a, fwd_b};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard empty, got=%b", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s got=%b exp=%b (pc,ifid,ifl,idex,idfl,fa,fb)", name, got, exp);
      end
    end
  endtask

  // Inputs are already driven; expect `exp` this cycle, sample at the falling
  // edge, then advance past the next rising edge.
  task automatic cycle_check(input string name, input logic [8:0] exp);
    exp_q.push_back(exp);
    @(negedge clock);
    compare_head(name);
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    failures = 0;
    exp_stall = 0;

    vecs[0]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    vecs[1]  = mk(5, 0, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, E_LU);
    vecs[2]  = mk(0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    vecs[3]  = mk(3, 9, 0, 9, 2'b10, 0, 0, 0, 0, 0, 0, 0, E_LU);
    vecs[4]  = mk(5, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    vecs[5]  = mk(6, 7, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, E_IDLE);
    vecs[6]  = mk(5, 0, 0, 5, 2'b10, 0, 0, 0, 0, 1, 0, 0, E_BR);
    vecs[7]  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, E_BR);
    vecs[8]  = mk(5, 0, 0, 5, 2'b10, 0, 0, 0, 0, 0, 1, 1, E_IDLE);
    vecs[9]  = mk(0, 0, 7, 0, 2'b00, 7, 7, 1, 1, 0, 0, 0, 9'b11010_1000);
    vecs[10] = mk(0, 0, 7, 0, 2'b00, 7, 7, 0, 1, 0, 0, 0, 9'b11010_0100);
    vecs[11] = mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0, E_IDLE);
    vecs[12] = mk(0, 0, 3, 12, 2'b00, 12, 12, 0, 1, 0, 0, 0, 9'b11010_0001);
    vecs[13] = mk(0, 0, 12, 12, 2'b00, 12, 12, 1, 1, 0, 0, 0, 9'b11010_1010);
    vecs[14] = mk(0, 0, 4, 0, 2'b00, 5, 6, 1, 1, 0, 0, 0, E_IDLE);
    vecs[15] = mk(8, 0, 0, 8, 2'b10, 0, 8, 0, 1, 0, 0, 0, 9'b00011_0001);

    // Reset: outputs forced low while reset is held.
    reset = 1'b1;
    clr_inputs();
    ex_rs = 5'd7; exmem_rd = 5'd7; exmem_regwrite = 1'b1;
    #3;
    exp_q.push_back(9'b0);
    compare_head("reset_outputs");
    check_val("reset_stall_cnt", int'(stall_cnt), 0);
    check_val("reset_mdu_timeout", int'(mdu_timeout), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    clr_inputs();
    @(posedge clock);
    #1;

    // Table of single-cycle cases; each stall vector contributes one count.
    for (int i = 0; i < 16; i++) begin
      drive_vec(vecs[i]);
      if (!vecs[i].exp[8]) exp_stall++;
      cycle_check($sformatf("vec%0d", i), vecs[i].exp);
    end
    clr_inputs();
    check_val("table_stall_cnt", int'(stall_cnt), exp_stall);
    check_val("sat_counting", int'(s_stall_cnt), exp_stall);

    // MDU: start, done four cycles later; branch during the wait is ignored.
    mdu_start = 1'b1;
    cycle_check("mdu_start", E_MDU);
    cycle_check("mdu_wait1", E_MDU);
    branch_taken = 1'b1;
    cycle_check("mdu_wait2_branch", E_MDU);
    branch_taken = 1'b0;
    cycle_check("mdu_wait3", E_MDU);
    mdu_done = 1'b1;
    cycle_check("mdu_done_release", E_IDLE);
    clr_inputs();
    cycle_check("mdu_after", E_IDLE);
    exp_stall += 4;
    check_val("mdu_stall_cnt", int'(stall_cnt), exp_stall);
    check_val("mdu_no_timeout", int'(mdu_timeout), 0);

    // Timeout: done never comes; 64 stalled cycles, released on the 64th wait cycle.
    mdu_start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      cycle_check($sformatf("to_stall%0d", k), E_MDU);
    end
    cycle_check("to_release", E_IDLE);
    mdu_start = 1'b0;
    exp_stall += 64;
    check_val("to_flag", int'(mdu_timeout), 1);
    check_val("to_stall_cnt", int'(stall_cnt), exp_stall);
    repeat (3) cycle_check("to_idle", E_IDLE);
    check_val("to_flag_sticky", int'(mdu_timeout), 1);
    check_val("sat_flag", int'(s_mdu_timeout), 1);
    check_val("sat_saturated", int'(s_stall_cnt), 7);

    // Reset in the middle of an MDU wait.
    ex_rs = 5'd7; exmem_rd = 5'd7; exmem_regwrite = 1'b1;
    mdu_start = 1'b1;
    repeat (3) cycle_check("pre_rst_wait", 9'b00000_1000);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(9'b0);
    compare_head("midrst_outputs");
    check_val("midrst_stall_cnt", int'(stall_cnt), 0);
    check_val("midrst_timeout", int'(mdu_timeout), 0);
    check_val("midrst_sat_cnt", int'(s_stall_cnt), 0);
    mdu_start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    cycle_check("post_rst_idle", 9'b11010_1000);
    // Only RUN produces a load-use bubble, so this proves the state returned.
    id_rs = 5'd5; ex_rt = 5'd5; ex_memctrl = 2'b10;
    cycle_check("post_rst_loaduse", 9'b00011_1000);
    clr_inputs();
    check_val("post_rst_stall_cnt", int'(stall_cnt), 1);

    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
